uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin scheduler sharing the single UART byte transmitter between two read-side byte FIFOs: source 0 carries SDRAM read-back data, source 1 carries status/echo bytes. It pops one byte at a time from the granted FIFO and hands it to the transmitter with a one-cycle trigger. It waits for the transmitter's end-of-frame pulse before issuing the next byte, and releases the grant after a bounded burst so neither source starves. A watchdog recovers the block if the transmitter never completes a frame.

## Interface
Parameters:
- MAX_BURST, 16, maximum bytes sent per grant; legal range 1..255.
- DONE_TIMEOUT, 65535, cycles allowed from tx_trig to tx_done before abort; legal range 2..65535.

Ports:
- sclk  in  1  system clock.
- s_rst_n  in  1  reset; synchronous, active-low.
- src0_empty  in  1  source 0 FIFO empty.
- src0_rd_en  out  1  source 0 FIFO read strobe; one cycle per byte.
- src0_rd_data  in  8  source 0 FIFO data; valid the cycle after src0_rd_en (non-showahead).
- src1_empty, src1_rd_en, src1_rd_data: same as source 0, for source 1.
- tx_trig  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to transmit; stable from tx_trig until the next LATCH.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- tx_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, RD, LATCH, TRIG, WAIT. All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- Reset values: state=IDLE; grant=00; src0_rd_en=src1_rd_en=0; tx_trig=0; tx_data=8'h00; tx_err=0; last_grant=source 1, so source 0 wins the first arbitration; burst_cnt=0; wd_cnt=0.
- IDLE:
  - If exactly one source is non-empty, grant that source.
  - If both are non-empty, grant the source that is not last_grant.
  - On a grant: burst_cnt=0, go to RD.
- RD: assert rd_en of the granted source for exactly one cycle, then go to LATCH.
- LATCH: tx_data <= granted rd_data, then go to TRIG.
- TRIG: tx_trig=1 for one cycle, wd_cnt=0, then go to WAIT.
- WAIT: wd_cnt increments every cycle.
  - On tx_done, burst_cnt increments. If the new burst_cnt < MAX_BURST and the granted source's empty is 0 in that cycle, go to RD with the same grant.
  - Otherwise on tx_done: last_grant <= grant, grant <= 00, go to IDLE.
  - If wd_cnt reaches DONE_TIMEOUT-1 without tx_done: pulse tx_err, last_grant <= grant, grant <= 00, go to IDLE. The byte is lost and is not retried.
  - tx_done takes priority over timeout in the same cycle.
- tx_done outside WAIT is ignored.
- Burst limit only forces a re-arbitration. If the other source is empty, IDLE re-grants the same source.
- The arbiter never reads an empty FIFO. Empty is sampled only in IDLE and at tx_done; the granted FIFO must not go empty between those samples, since the arbiter is its only reader.
- burst_cnt is 8 bits and wd_cnt is 16 bits. Neither wraps: both are cleared on every grant or trigger before they can overflow.

## Timing
- Arbitration latency: a source is seen non-empty in IDLE at cycle 0. Then rd_en is high in cycle 1, tx_data updates at the end of cycle 2, and tx_trig is high in cycle 3.
- Inter-byte gap within a burst: tx_done at cycle t gives rd_en at t+1 and tx_trig at t+3.
- Grant switch: tx_done at cycle t gives grant=00 in IDLE at t+1, the new grant's rd_en at t+2, and tx_trig at t+4.
- grant changes only on IDLE entry or exit. It is stable from RD through WAIT.
- Synchronous reset in any state returns the block to IDLE with reset values on the next edge. No FIFO read or trigger is issued during that cycle.
- Only one rd_en is ever high, and at most one rd_en pulse is issued per tx_trig.

## Test plan
- Single byte on src0 (8'hA5), src1 empty: rd_en in cycle 1, tx_trig in cycle 3 with tx_data=A5. After tx_done, grant returns to 00.
- Both sources full, MAX_BURST=4: 4 bytes from src0, then 4 from src1, then 4 from src0, alternating. Each switch takes the 4-cycle tx_done-to-tx_trig gap.
- src1 only, 20 bytes, MAX_BURST=16: 16 bytes, a one-cycle IDLE with grant=00, then 4 more bytes from src1 with no loss or duplication.
- tx_done held low, DONE_TIMEOUT=100: tx_err pulses exactly 100 cycles after tx_trig, grant becomes 00, and the next arbitration favours the other source.
- s_rst_n asserted during WAIT and during RD: all outputs are at reset values on the next edge and no extra rd_en occurs. After release, src0 is served first.
- Spurious tx_done pulse in IDLE and in TRIG: no state change and no extra rd_en.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the UART TX arbiter, its two read-side byte FIFOs
// and the shared byte transmitter.
interface uart_tx_arb_if;
  logic       src0_empty;
  logic       src0_rd_en;
  logic [7:0] src0_rd_data;
  logic       src1_empty;
  logic       src1_rd_en;
  logic [7:0] src1_rd_data;
  logic       tx_trig;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [1:0] grant;
  logic       tx_err;

  // master: the arbiter; slave: the FIFOs plus transmitter around it.
  modport master (
    input  src0_empty, src0_rd_data, src1_empty, src1_rd_data, tx_done,
    output src0_rd_en, src1_rd_en, tx_trig, tx_data, grant, tx_err
  );

  modport slave (
    output src0_empty, src0_rd_data, src1_empty, src1_rd_data, tx_done,
    input  src0_rd_en, src1_rd_en, tx_trig, tx_data, grant, tx_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler feeding one UART byte transmitter from two byte FIFOs,
// with a bounded burst per grant and a watchdog on the transmitter's done pulse.
module uart_tx_arb #(
  parameter int MAX_BURST    = 16,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  uart_tx_arb_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_TRIG,
    ST_WAIT
  } state_t;

  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
  // Abort decision is taken on the cycle whose increment would reach DONE_TIMEOUT-1,
  // so tx_err appears exactly DONE_TIMEOUT cycles after tx_trig.
  localparam logic [15:0] WD_LAST   = 16'(DONE_TIMEOUT - 2);

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_last_grant;   // 1 = source 1 was the previous owner
  logic        r_src0_rd_en;
  logic        r_src1_rd_en;
  logic        r_tx_trig;
  logic [7:0]  r_tx_data;
  logic        r_tx_err;
  logic [7:0]  r_burst_cnt;
  logic [15:0] r_wd_cnt;

  logic        w_pick_src0;
  logic        w_any_ready;
  logic        w_gnt_empty;
  logic [7:0]  w_gnt_data;
  logic [7:0]  w_burst_next;

  assign w_any_ready  = !bus.src0_empty || !bus.src1_empty;
  assign w_pick_src0  = !bus.src0_empty && (bus.src1_empty || r_last_grant);
  assign w_gnt_empty  = r_grant[1] ? bus.src1_empty   : bus.src0_empty;
  assign w_gnt_data   = r_grant[1] ? bus.src1_rd_data : bus.src0_rd_data;
  assign w_burst_next = r_burst_cnt + 8'd1;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values; the one-cycle strobes default low each cycle and are only
  // raised on the transition into the state that owns them.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_src0_rd_en <= 1'b0;
      r_src1_rd_en <= 1'b0;
      r_tx_trig    <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_err     <= 1'b0;
      r_burst_cnt  <= 8'd0;
      r_wd_cnt     <= 16'd0;
    end else begin
      r_src0_rd_en <= 1'b0;
      r_src1_rd_en <= 1'b0;
      r_tx_trig    <= 1'b0;
      r_tx_err     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_ready) begin
            r_grant      <= w_pick_src0 ? 2'b01 : 2'b10;
            r_src0_rd_en <= w_pick_src0;
            r_src1_rd_en <= !w_pick_src0;
            r_burst_cnt  <= 8'd0;
            r_state      <= ST_RD;
          end
        end

        ST_RD: r_state <= ST_LATCH;

        ST_LATCH: begin
          r_tx_data <= w_gnt_data;
          r_tx_trig <= 1'b1;
          r_state   <= ST_TRIG;
        end

        ST_TRIG: begin
          r_wd_cnt <= 16'd0;
          r_state  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.tx_done) begin
            r_burst_cnt <= w_burst_next;
            if (w_burst_next < BURST_MAX && !w_gnt_empty) begin
              r_src0_rd_en <= r_grant[0];
              r_src1_rd_en <= r_grant[1];
              r_state      <= ST_RD;
            end else begin
              r_last_grant <= r_grant[1];
              r_grant      <= 2'b00;
              r_state      <= ST_IDLE;
            end
          end else if (r_wd_cnt == WD_LAST) begin
            // Byte is dropped; ownership rotates as after a normal burst end.
            r_tx_err     <= 1'b1;
            r_last_grant <= r_grant[1];
            r_grant      <= 2'b00;
            r_state      <= ST_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
        end

        default: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.src0_rd_en = r_src0_rd_en;
  assign bus.src1_rd_en = r_src1_rd_en;
  assign bus.tx_trig    = r_tx_trig;
  assign bus.tx_data    = r_tx_data;
  assign bus.grant      = r_grant;
  assign bus.tx_err     = r_tx_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: two FIFO models, an auto-responding transmitter
// model and per-scenario tasks with hand-computed expectations.
module tb_uart_tx_arb;
  localparam int MAX_BURST    = 4;
  localparam int DONE_TIMEOUT = 100;
  localparam int DONE_GAP     = 3;

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 sclk = ~sclk;

  uart_tx_arb_if bus ();

  logic model_done = 1'b0;
  logic man_done   = 1'b0;
  bit   auto_done  = 1'b0;
  assign bus.tx_done = model_done | man_done;

  uart_tx_arb #(
    .MAX_BURST   (MAX_BURST),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // FIFO models: write pointer owned by the stimulus, read pointer by the pop process.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  assign bus.src0_empty = (wr0 == rd0);
  assign bus.src1_empty = (wr1 == rd1);

  int cyc       = 0;
  int underflow = 0;

  always @(posedge sclk) begin
    cyc <= cyc + 1;
    if (bus.src0_rd_en) begin
      if (wr0 == rd0) underflow <= underflow + 1;
      else begin
        bus.src0_rd_data <= mem0[rd0 % 256];
        rd0 <= rd0 + 1;
      end
    end
    if (bus.src1_rd_en) begin
      if (wr1 == rd1) underflow <= underflow + 1;
      else begin
        bus.src1_rd_data <= mem1[rd1 % 256];
        rd1 <= rd1 + 1;
      end
    end
  end

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] data;
    int         cyc;
  } trig_t;

  trig_t tlog [$];
  int rd_cnt   = 0;
  int both_rd  = 0;
  int done_cnt = 0;

  // Monitor plus transmitter model: done pulses DONE_GAP cycles after each trigger.
  always @(negedge sclk) begin
    if (bus.tx_trig) tlog.push_back('{gnt: bus.grant, data: bus.tx_data, cyc: cyc});
    if (bus.src0_rd_en || bus.src1_rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.src0_rd_en && bus.src1_rd_en) both_rd <= both_rd + 1;
    model_done <= 1'b0;
    if (!auto_done) done_cnt <= 0;
    else if (bus.tx_trig) done_cnt <= DONE_GAP;
    else if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) model_done <= 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge sclk);
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wr0 % 256] = b;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1 % 256] = b;
    wr1 = wr1 + 1;
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    step(2);
    s_rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, input string what);
    int k = 0;
    while (tlog.size() < n && k < budget) begin
      step();
      k++;
    end
    tests++;
    if (tlog.size() < n) begin
      fails++;
      $display("FAIL %s: timeout, got %0d triggers, required %0d", what, tlog.size(), n);
    end
  endtask

  task automatic check_log(input int i, input logic [1:0] g, input logic [7:0] d, input string what);
    tests++;
    if (i >= tlog.size() || tlog[i].gnt !== g || tlog[i].data !== d) begin
      fails++;
      if (i >= tlog.size())
        $display("FAIL %s[%0d]: missing entry, required grant=%b data=%h", what, i, g, d);
      else
        $display("FAIL %s[%0d]: got grant=%b data=%h, required grant=%b data=%h",
                 what, i, tlog[i].gnt, tlog[i].data, g, d);
    end
  endtask

  task automatic check_outs_reset(input string what);
    logic [13:0] got;
    got = {bus.grant, bus.src0_rd_en, bus.src1_rd_en, bus.tx_trig, bus.tx_data, bus.tx_err};
    tests++;
    if (got !== 14'h0) begin
      fails++;
      $display("FAIL %s: outputs {grant,rd0,rd1,trig,data,err}=%h, required 0", what, got);
    end
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    step(3);
    check_outs_reset("reset_state");
    s_rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single();
    auto_done = 1'b1;
    tlog.delete();
    push0(8'hA5);                         // cycle 0
    step();                               // cycle 1
    tests++;
    if ({bus.src0_rd_en, bus.src1_rd_en, bus.grant} !== 4'b1001) begin
      fails++;
      $display("FAIL single_rd: {rd0,rd1,grant}=%b, required 1001",
               {bus.src0_rd_en, bus.src1_rd_en, bus.grant});
    end
    step();                               // cycle 2
    tests++;
    if (bus.src0_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL single_rd_width: rd0=%b, required 0", bus.src0_rd_en);
    end
    step();                               // cycle 3
    tests++;
    if (bus.tx_trig !== 1'b1 || bus.tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_trig: trig=%b data=%h, required trig=1 data=a5", bus.tx_trig, bus.tx_data);
    end
    step(3);                              // cycle 6: tx_done seen in WAIT
    tests++;
    if (bus.grant !== 2'b01) begin
      fails++;
      $display("FAIL single_hold: grant=%b, required 01", bus.grant);
    end
    step();                               // cycle 7: back in IDLE
    tests++;
    if (bus.grant !== 2'b00) begin
      fails++;
      $display("FAIL single_release: grant=%b, required 00", bus.grant);
    end
    step(3);
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    logic [7:0] d;
    int gap;
    do_reset();
    tlog.delete();
    for (int i = 0; i < 8; i++) begin
      push0(8'h10 + 8'(i));
      push1(8'h20 + 8'(i));
    end
    wait_log(16, 400, "alt_count");
    for (int i = 0; i < 16; i++) begin
      g = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
      d = ((g == 2'b01) ? 8'h10 : 8'h20) + 8'((i / 8) * 4 + i % 4);
      check_log(i, g, d, "alt");
    end
    for (int i = 1; i < 16 && i < tlog.size(); i++) begin
      gap = tlog[i].cyc - tlog[i-1].cyc;
      tests++;
      if (gap !== ((i % 4 == 0) ? 7 : 6)) begin
        fails++;
        $display("FAIL alt_gap[%0d]: got %0d cycles, required %0d", i, gap, (i % 4 == 0) ? 7 : 6);
      end
    end
    step(8);
  endtask

  task automatic test_burst_limit();
    int gap;
    tlog.delete();
    for (int i = 0; i < 6; i++) push1(8'h30 + 8'(i));
    wait_log(6, 200, "burst_count");
    for (int i = 0; i < 6; i++) check_log(i, 2'b10, 8'h30 + 8'(i), "burst");
    if (tlog.size() >= 6) begin
      gap = tlog[4].cyc - tlog[3].cyc;
      tests++;
      if (gap !== 7) begin
        fails++;
        $display("FAIL burst_regrant_gap: got %0d cycles, required 7", gap);
      end
    end
    step(8);
    tests++;
    if (!bus.src1_empty || tlog.size() !== 6 || underflow !== 0) begin
      fails++;
      $display("FAIL burst_drain: empty=%b trigs=%0d underflow=%0d, required 1/6/0",
               bus.src1_empty, tlog.size(), underflow);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    int dt;
    auto_done = 1'b0;
    tlog.delete();
    push1(8'h50);
    wait_log(1, 20, "wd_trig");
    push0(8'h41);
    push1(8'h51);
    while (!bus.tx_err && k < 200) begin
      step();
      k++;
    end
    dt = (tlog.size() > 0) ? cyc - tlog[0].cyc : -1;
    tests++;
    if (!bus.tx_err || dt !== DONE_TIMEOUT || bus.grant !== 2'b00) begin
      fails++;
      $display("FAIL wd_abort: err=%b delay=%0d grant=%b, required err=1 delay=%0d grant=00",
               bus.tx_err, dt, bus.grant, DONE_TIMEOUT);
    end
    auto_done = 1'b1;
    step();
    tests++;
    if (bus.tx_err !== 1'b0 || bus.grant !== 2'b01) begin
      fails++;
      $display("FAIL wd_next: err=%b grant=%b, required err=0 grant=01", bus.tx_err, bus.grant);
    end
    wait_log(3, 100, "wd_after");
    check_log(1, 2'b01, 8'h41, "wd_after");
    check_log(2, 2'b10, 8'h51, "wd_after");
    step(8);
  endtask

  task automatic test_reset_mid();
    int r0;
    auto_done = 1'b0;
    tlog.delete();
    r0 = rd_cnt;
    push1(8'h60);
    wait_log(1, 20, "rst_wait_trig");
    step(3);
    s_rst_n = 1'b0;
    step();
    check_outs_reset("rst_in_wait");
    s_rst_n = 1'b1;
    step(2);
    push0(8'h70);                         // cycle 0
    step();                               // cycle 1: RD
    tests++;
    if (bus.src0_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL rst_rd_entry: rd0=%b, required 1", bus.src0_rd_en);
    end
    s_rst_n = 1'b0;
    step();
    check_outs_reset("rst_in_rd");
    step(2);
    check_outs_reset("rst_hold");
    s_rst_n = 1'b1;
    auto_done = 1'b1;
    push0(8'h72);
    push1(8'h73);
    wait_log(3, 100, "rst_after");
    check_log(0, 2'b10, 8'h60, "rst_after");
    check_log(1, 2'b01, 8'h72, "rst_after");
    check_log(2, 2'b10, 8'h73, "rst_after");
    step(8);
    tests++;
    if (rd_cnt - r0 !== 4) begin
      fails++;
      $display("FAIL rst_rd_count: got %0d reads, required 4", rd_cnt - r0);
    end
  endtask

  task automatic test_spurious();
    int r0;
    auto_done = 1'b0;
    step(2);
    tlog.delete();
    r0 = rd_cnt;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step(2);
    tests++;
    if (bus.grant !== 2'b00 || rd_cnt !== r0 || tlog.size() !== 0) begin
      fails++;
      $display("FAIL spur_idle: grant=%b reads=%0d trigs=%0d, required 00/0/0",
               bus.grant, rd_cnt - r0, tlog.size());
    end
    push0(8'h80);                         // cycle 0
    step(3);                              // cycle 3: TRIG
    tests++;
    if (bus.tx_trig !== 1'b1 || bus.tx_data !== 8'h80) begin
      fails++;
      $display("FAIL spur_trig: trig=%b data=%h, required trig=1 data=80", bus.tx_trig, bus.tx_data);
    end
    man_done = 1'b1;
    step();                               // cycle 4: WAIT
    man_done = 1'b0;
    step();                               // cycle 5
    tests++;
    if (bus.grant !== 2'b01 || bus.src0_rd_en !== 1'b0 || tlog.size() !== 1) begin
      fails++;
      $display("FAIL spur_in_trig: grant=%b rd0=%b trigs=%0d, required 01/0/1",
               bus.grant, bus.src0_rd_en, tlog.size());
    end
    man_done = 1'b1;
    step();                               // cycle 6: IDLE
    man_done = 1'b0;
    tests++;
    if (bus.grant !== 2'b00) begin
      fails++;
      $display("FAIL spur_real_done: grant=%b, required 00", bus.grant);
    end
    step(4);
    tests++;
    if (rd_cnt - r0 !== 1 || underflow !== 0 || both_rd !== 0) begin
      fails++;
      $display("FAIL spur_totals: reads=%0d underflow=%0d both_rd=%0d, required 1/0/0",
               rd_cnt - r0, underflow, both_rd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_burst_limit();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
